// File: rtl/tanh_sequencer.sv
// rtl/tanh_sequencer.sv - single-op tanh(x) sequencer with local saturation/linear paths and engine dispatch
module tanh_sequencer #(
    parameter int unsigned SAT_EXP = 130,
    parameter int unsigned LIN_EXP = 123,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        in_valid,
    input  logic [31:0] in_x,
    output logic        in_ready,
    output logic        eng_start,
    output logic [31:0] eng_x,
    input  logic        eng_done,
    input  logic [31:0] eng_y,
    output logic        out_valid,
    output logic [31:0] out_y,
    input  logic        out_ready,
    output logic [1:0]  region,
    output logic        err_timeout
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [1:0]  REG_HYP  = 2'b00;
    localparam logic [1:0]  REG_SAT  = 2'b01;
    localparam logic [1:0]  REG_LIN  = 2'b10;
    localparam logic [1:0]  REG_NONE = 2'b11;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, DISPATCH, WAIT, HOLD} state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   count;
    logic [7:0]      x_exp;
    logic            is_nan;
    logic            is_sat;
    logic            is_lin;
    logic            accept;
    logic [1:0]      x_region;
    logic [31:0]     local_y;
    logic            wait_expired;

    // NaN is checked before saturation so a NaN payload propagates untouched.
    assign x_exp   = in_x[30:23];
    assign is_nan  = (x_exp == 8'hFF) && (in_x[22:0] != 23'd0);
    assign is_sat  = !is_nan && (x_exp >= 8'(SAT_EXP));
    assign is_lin  = !is_nan && (x_exp < 8'(LIN_EXP));

    always_comb begin
        x_region = REG_HYP;
        local_y  = in_x;
        if (is_nan) begin
            x_region = REG_SAT;
        end else if (is_sat) begin
            x_region = REG_SAT;
            local_y  = {in_x[31], 31'h3F80_0000};
        end else if (is_lin) begin
            x_region = REG_LIN;
        end
    end

    assign in_ready     = (state == IDLE);
    assign accept       = in_valid && in_ready;
    assign eng_start    = (state == DISPATCH);
    assign out_valid    = (state == HOLD);
    assign wait_expired = (count == CW'(TIMEOUT - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (accept) state_next = (x_region == REG_HYP) ? DISPATCH : HOLD;
            DISPATCH: state_next = WAIT;
            WAIT:     if (eng_done || wait_expired) state_next = HOLD;
            HOLD:     if (out_ready) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers; eng_done is only honoured in WAIT so stale pulses are dropped.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            count       <= '0;
            eng_x       <= '0;
            out_y       <= '0;
            region      <= REG_NONE;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        region <= x_region;
                        if (x_region == REG_HYP) begin
                            eng_x <= in_x;
                        end else begin
                            out_y <= local_y;
                        end
                    end
                end
                DISPATCH: count <= '0;
                WAIT: begin
                    if (eng_done) begin
                        out_y <= eng_y;
                    end else if (wait_expired) begin
                        out_y       <= QNAN;
                        err_timeout <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
